lsu_line_splitter: RTL and testbench

Parametrised warp memory-request splitter between the LSU issue stage and the memory/cache port of the streaming multiprocessor. It accepts one warp-wide load/store request (per-lane addresses plus active mask) and emits one transaction per distinct cache line touched, each with its lane sub-mask and a last flag. This generation adds configurable line size and warp width, ready/valid backpressure on both sides, and back-to-back request overlap. It also adds zero-mask handling, a flush, and a per-request completion report with a transaction count.

---
 rtl/lsu_line_splitter.sv | 252 +++++++++++++++++++++++++
 tb/tb_lsu_line_splitter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_line_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_line_splitter
//  Description : Splits one warp-wide load/store request into one memory
//                transaction per distinct cache line touched. Each transaction
//                carries the line-aligned address, the sub-mask of lanes it
//                serves and a last flag. A completion pulse reports how many
//                transactions the request produced.
//
//  Ports
//    clk, rst_n        clock, asynchronous active-low reset
//    flush             synchronous abort of the split in progress
//    req_*             warp request (valid/ready, warp id, store flag,
//                      lane mask, packed per-lane byte addresses)
//    tx_*              transaction stream (valid/ready, warp id, store flag,
//                      line address, lane sub-mask, last)
//    done_*            one-cycle completion pulse with warp id and tx count
//
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_line_splitter #(
    parameter int WARP_SIZE  = 32,
    parameter int NUM_WARPS  = 4,
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 128,
    parameter int WARP_ID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int CNT_W      = $clog2(WARP_SIZE + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    // request side
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [WARP_ID_W-1:0]        req_warp,
    input  logic                        req_is_store,
    input  logic [WARP_SIZE-1:0]        req_mask,
    input  logic [WARP_SIZE*ADDR_W-1:0] req_addr,
    // transaction side
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [WARP_ID_W-1:0]        tx_warp,
    output logic                        tx_is_store,
    output logic [ADDR_W-1:0]           tx_line_addr,
    output logic [WARP_SIZE-1:0]        tx_mask,
    output logic                        tx_last,
    // completion report
    output logic                        done_valid,
    output logic [WARP_ID_W-1:0]        done_warp,
    output logic [CNT_W-1:0]            done_tx_count
);

    localparam int LINE_SHIFT = $clog2(LINE_BYTES);
    localparam int TAG_W      = ADDR_W - LINE_SHIFT;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                     r_state;
    logic [WARP_SIZE-1:0]       r_remaining;
    logic [CNT_W-1:0]           r_count;
    logic [WARP_ID_W-1:0]       r_warp;
    logic                       r_is_store;
    // Only the line tag of each lane is kept; the byte offset never matters.
    logic [WARP_SIZE*TAG_W-1:0] r_tag;
    logic                       r_done_valid;
    logic [WARP_ID_W-1:0]       r_done_warp;
    logic [CNT_W-1:0]           r_done_count;
    // A zero-mask request accepted on the same cycle as a last handshake
    // would need a second done pulse that cycle; it is parked here and
    // reported one cycle later.
    logic                       r_zp_valid;
    logic [WARP_ID_W-1:0]       r_zp_warp;

    state_t                     w_state_nxt;
    logic [WARP_SIZE-1:0]       w_remaining_nxt;
    logic [CNT_W-1:0]           w_count_nxt;
    logic [WARP_ID_W-1:0]       w_warp_nxt;
    logic                       w_is_store_nxt;
    logic [WARP_SIZE*TAG_W-1:0] w_tag_nxt;
    logic                       w_done_valid_nxt;
    logic [WARP_ID_W-1:0]       w_done_warp_nxt;
    logic [CNT_W-1:0]           w_done_count_nxt;
    logic                       w_zp_valid_nxt;
    logic [WARP_ID_W-1:0]       w_zp_warp_nxt;

    // ------------------------------------------------------------------
    // Per-lane tag extraction and line matching
    // ------------------------------------------------------------------
    logic [WARP_SIZE*TAG_W-1:0]      w_req_tag;
    logic [WARP_SIZE*LINE_SHIFT-1:0] w_lsb_bits;
    logic                            w_unused_lsbs;
    logic [TAG_W-1:0]                w_lead_tag;
    logic [WARP_SIZE-1:0]            w_match;

    genvar gi;
    generate
        for (gi = 0; gi < WARP_SIZE; gi++) begin : g_lane
            assign w_req_tag[gi*TAG_W +: TAG_W] =
                req_addr[gi*ADDR_W+LINE_SHIFT +: TAG_W];
            assign w_lsb_bits[gi*LINE_SHIFT +: LINE_SHIFT] =
                req_addr[gi*ADDR_W +: LINE_SHIFT];
            // Full upper-bit compare: lanes in the same line share one tx.
            assign w_match[gi] = r_remaining[gi] &&
                (r_tag[gi*TAG_W +: TAG_W] == w_lead_tag);
        end
    endgenerate

    assign w_unused_lsbs = ^w_lsb_bits;

    // Leader = lowest-index lane still pending; its tag names the line.
    always_comb begin
        logic w_found;
        w_found    = 1'b0;
        w_lead_tag = '0;
        for (int i = 0; i < WARP_SIZE; i++) begin
            if (r_remaining[i] && !w_found) begin
                w_found    = 1'b1;
                w_lead_tag = r_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (combinational from registered state, held under stall)
    // ------------------------------------------------------------------
    logic w_tx_valid;
    logic w_tx_last;
    logic w_tx_fire;
    logic w_accept;

    assign w_tx_valid = (r_state == S_SPLIT);
    assign w_tx_last  = ((r_remaining & ~w_match) == '0);
    assign w_tx_fire  = w_tx_valid & tx_ready & ~flush;
    assign req_ready  = ~flush &
                        ((r_state == S_IDLE) | (w_tx_valid & tx_ready & w_tx_last));
    assign w_accept   = req_valid & req_ready;

    assign tx_valid     = w_tx_valid;
    assign tx_warp      = w_tx_valid ? r_warp : '0;
    assign tx_is_store  = w_tx_valid & r_is_store;
    assign tx_line_addr = w_tx_valid ? {w_lead_tag, {LINE_SHIFT{1'b0}}} : '0;
    assign tx_mask      = w_tx_valid ? w_match : '0;
    assign tx_last      = w_tx_valid & w_tx_last;

    assign done_valid    = r_done_valid;
    assign done_warp     = r_done_warp;
    assign done_tx_count = r_done_count;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_remaining_nxt  = r_remaining;
        w_count_nxt      = r_count;
        w_warp_nxt       = r_warp;
        w_is_store_nxt   = r_is_store;
        w_tag_nxt        = r_tag;
        w_done_valid_nxt = 1'b0;
        w_done_warp_nxt  = r_done_warp;
        w_done_count_nxt = r_done_count;
        w_zp_valid_nxt   = 1'b0;
        w_zp_warp_nxt    = r_zp_warp;

        // A parked zero-mask completion belongs to a finished request, so it
        // is reported even when a flush arrives.
        if (r_zp_valid) begin
            w_done_valid_nxt = 1'b1;
            w_done_warp_nxt  = r_zp_warp;
            w_done_count_nxt = '0;
        end

        if (flush) begin
            w_state_nxt     = S_IDLE;
            w_remaining_nxt = '0;
            w_count_nxt     = '0;
        end else begin
            if (w_tx_fire) begin
                w_remaining_nxt = r_remaining & ~w_match;
                w_count_nxt     = r_count + CNT_W'(1);
                if (w_tx_last) begin
                    w_state_nxt      = S_IDLE;
                    w_done_valid_nxt = 1'b1;
                    w_done_warp_nxt  = r_warp;
                    w_done_count_nxt = r_count + CNT_W'(1);
                end
            end

            if (w_accept) begin
                w_warp_nxt     = req_warp;
                w_is_store_nxt = req_is_store;
                w_tag_nxt      = w_req_tag;
                if (req_mask != '0) begin
                    w_state_nxt     = S_SPLIT;
                    w_remaining_nxt = req_mask;
                    w_count_nxt     = '0;
                end else begin
                    w_state_nxt     = S_IDLE;
                    w_remaining_nxt = '0;
                    w_count_nxt     = '0;
                    if (w_done_valid_nxt) begin
                        w_zp_valid_nxt = 1'b1;
                        w_zp_warp_nxt  = req_warp;
                    end else begin
                        w_done_valid_nxt = 1'b1;
                        w_done_warp_nxt  = req_warp;
                        w_done_count_nxt = '0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_count      <= '0;
            r_warp       <= '0;
            r_is_store   <= 1'b0;
            r_tag        <= '0;
            r_done_valid <= 1'b0;
            r_done_warp  <= '0;
            r_done_count <= '0;
            r_zp_valid   <= 1'b0;
            r_zp_warp    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_count      <= w_count_nxt;
            r_warp       <= w_warp_nxt;
            r_is_store   <= w_is_store_nxt;
            r_tag        <= w_tag_nxt;
            r_done_valid <= w_done_valid_nxt;
            r_done_warp  <= w_done_warp_nxt;
            r_done_count <= w_done_count_nxt;
            r_zp_valid   <= w_zp_valid_nxt;
            r_zp_warp    <= w_zp_warp_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_line_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_line_splitter
//  Description : Directed self-checking bench for lsu_line_splitter
//                (coalesced, split, divergent, backpressure, zero mask,
//                overlap, flush, asynchronous reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_line_splitter;

    localparam int WARP_SIZE = 32;
    localparam int ADDR_W    = 32;
    localparam int WARP_ID_W = 2;
    localparam int CNT_W     = 6;

    logic                        clk;
    logic                        rst_n;
    logic                        flush;
    logic                        req_valid;
    logic                        req_ready;
    logic [WARP_ID_W-1:0]        req_warp;
    logic                        req_is_store;
    logic [WARP_SIZE-1:0]        req_mask;
    logic [WARP_SIZE*ADDR_W-1:0] req_addr;
    logic                        tx_valid;
    logic                        tx_ready;
    logic [WARP_ID_W-1:0]        tx_warp;
    logic                        tx_is_store;
    logic [ADDR_W-1:0]           tx_line_addr;
    logic [WARP_SIZE-1:0]        tx_mask;
    logic                        tx_last;
    logic                        done_valid;
    logic [WARP_ID_W-1:0]        done_warp;
    logic [CNT_W-1:0]            done_tx_count;

    int vectors    = 0;
    int miscompares = 0;

    lsu_line_splitter #(
        .WARP_SIZE (WARP_SIZE),
        .NUM_WARPS (4),
        .ADDR_W    (ADDR_W),
        .LINE_BYTES(128)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_warp     (req_warp),
        .req_is_store (req_is_store),
        .req_mask     (req_mask),
        .req_addr     (req_addr),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_warp      (tx_warp),
        .tx_is_store  (tx_is_store),
        .tx_line_addr (tx_line_addr),
        .tx_mask      (tx_mask),
        .tx_last      (tx_last),
        .done_valid   (done_valid),
        .done_warp    (done_warp),
        .done_tx_count(done_tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_linear(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride);
        for (int i = 0; i < WARP_SIZE; i++)
            req_addr[i*ADDR_W +: ADDR_W] = base + stride * ADDR_W'(i);
    endtask

    // Lanes 0-15 at 0x1000, lanes 16-31 at 0x1080.
    task automatic set_split();
        for (int i = 0; i < WARP_SIZE; i++)
            req_addr[i*ADDR_W +: ADDR_W] = (i < 16) ? 32'h1000 : 32'h1080;
    endtask

    task automatic present(input logic [WARP_ID_W-1:0] w, input logic st, input logic [WARP_SIZE-1:0] m);
        req_valid    = 1'b1;
        req_warp     = w;
        req_is_store = st;
        req_mask     = m;
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        req_valid    = 1'b0;
        req_warp     = '0;
        req_is_store = 1'b0;
        req_mask     = '0;
        req_addr     = '0;
        tx_ready     = 1'b1;

        // ---------------- reset state ----------------
        #12;
        check("rst_tx_valid",  64'(tx_valid), 64'd0);
        check("rst_tx_mask",   64'(tx_mask), 64'd0);
        check("rst_tx_line",   64'(tx_line_addr), 64'd0);
        check("rst_done",      64'(done_valid), 64'd0);
        check("rst_done_cnt",  64'(done_tx_count), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", 64'(req_ready), 64'd1);

        // ---------------- coalesced ----------------
        set_linear(32'h1000, 32'd4);
        present(2'd0, 1'b0, 32'hFFFF_FFFF);
        tick();
        req_valid = 1'b0;
        check("coal_valid", 64'(tx_valid), 64'd1);
        check("coal_line",  64'(tx_line_addr), 64'h1000);
        check("coal_mask",  64'(tx_mask), 64'hFFFF_FFFF);
        check("coal_last",  64'(tx_last), 64'd1);
        tick();
        check("coal_done",  64'(done_valid), 64'd1);
        check("coal_cnt",   64'(done_tx_count), 64'd1);
        check("coal_idle",  64'(tx_valid), 64'd0);

        // ---------------- split + backpressure + overlap ----------------
        set_split();
        tx_ready = 1'b0;
        present(2'd1, 1'b1, 32'hFFFF_FFFF);
        tick();
        req_valid = 1'b0;
        check("split_tx1_line",  64'(tx_line_addr), 64'h1000);
        check("split_tx1_mask",  64'(tx_mask), 64'h0000_FFFF);
        check("split_tx1_last",  64'(tx_last), 64'd0);
        check("split_tx1_warp",  64'(tx_warp), 64'd1);
        check("split_tx1_store", 64'(tx_is_store), 64'd1);
        check("split_busy",      64'(req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_line", 64'(tx_line_addr), 64'h1000);
            check("bp_mask", 64'(tx_mask), 64'h0000_FFFF);
            check("bp_last", 64'(tx_last), 64'd0);
            check("bp_nodone", 64'(done_valid), 64'd0);
        end
        tx_ready = 1'b1;
        tick();
        check("split_tx2_line", 64'(tx_line_addr), 64'h1080);
        check("split_tx2_mask", 64'(tx_mask), 64'hFFFF_0000);
        check("split_tx2_last", 64'(tx_last), 64'd1);
        check("split_nodone",   64'(done_valid), 64'd0);
        // Overlap: new request offered during the last handshake.
        set_linear(32'h2000, 32'd4);
        present(2'd2, 1'b0, 32'hFFFF_FFFF);
        check("ovl_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check("split_done",      64'(done_valid), 64'd1);
        check("split_done_warp", 64'(done_warp), 64'd1);
        check("split_done_cnt",  64'(done_tx_count), 64'd2);
        check("ovl_valid",       64'(tx_valid), 64'd1);
        check("ovl_line",        64'(tx_line_addr), 64'h2000);
        check("ovl_warp",        64'(tx_warp), 64'd2);
        tick();
        check("ovl_done_warp", 64'(done_warp), 64'd2);
        check("ovl_done_cnt",  64'(done_tx_count), 64'd1);

        // ---------------- fully divergent ----------------
        set_linear(32'h4000, 32'd128);
        present(2'd3, 1'b0, 32'hFFFF_FFFF);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < WARP_SIZE; i++) begin
            check("div_line", 64'(tx_line_addr), 64'h4000 + 64'(128 * i));
            check("div_mask", 64'(tx_mask), 64'd1 << i);
            check("div_last", 64'(tx_last), (i == WARP_SIZE - 1) ? 64'd1 : 64'd0);
            tick();
        end
        check("div_done",      64'(done_valid), 64'd1);
        check("div_done_warp", 64'(done_warp), 64'd3);
        check("div_done_cnt",  64'(done_tx_count), 64'd32);

        // ---------------- zero mask ----------------
        tick();
        present(2'd2, 1'b0, 32'h0);
        check("zero_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check("zero_novalid", 64'(tx_valid), 64'd0);
        check("zero_done",    64'(done_valid), 64'd1);
        check("zero_cnt",     64'(done_tx_count), 64'd0);
        check("zero_warp",    64'(done_warp), 64'd2);
        tick();
        check("zero_pulse", 64'(done_valid), 64'd0);

        // ---------------- flush ----------------
        set_split();
        tx_ready = 1'b0;
        present(2'd1, 1'b0, 32'hFFFF_FFFF);
        tick();
        req_valid = 1'b0;
        check("fl_tx1", 64'(tx_valid), 64'd1);
        flush    = 1'b1;
        tx_ready = 1'b1;
        #1;
        check("fl_noready", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_novalid", 64'(tx_valid), 64'd0);
        check("fl_ready",   64'(req_ready), 64'd1);
        check("fl_nodone",  64'(done_valid), 64'd0);
        tick();
        check("fl_nodone2", 64'(done_valid), 64'd0);

        // ---------------- asynchronous reset mid-split ----------------
        tx_ready = 1'b0;
        present(2'd3, 1'b1, 32'hFFFF_FFFF);
        tick();
        req_valid = 1'b0;
        check("ar_tx1", 64'(tx_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(tx_valid), 64'd0);
        check("ar_mask",  64'(tx_mask), 64'd0);
        check("ar_line",  64'(tx_line_addr), 64'd0);
        check("ar_warp",  64'(tx_warp), 64'd0);
        check("ar_store", 64'(tx_is_store), 64'd0);
        check("ar_done",  64'(done_valid), 64'd0);
        tick();
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        tick();
        check("ar_post_valid", 64'(tx_valid), 64'd0);
        check("ar_post_done",  64'(done_valid), 64'd0);
        check("ar_post_ready", 64'(req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
